// File: rtl/seg_pkg.sv
// Shared constants, state type and helpers for the multiplexed 7-segment scan controller.
// Segment vectors are active-low, ordered {a,b,c,d,e,f,g}.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;

  typedef enum logic {S_SHOW, S_GAP} state_t;

  // Index 0 is the rightmost entry.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // A digit is a leading zero when it is not digit 0 and it and every more
  // significant nibble are zero. Unused upper nibbles must be passed as zero.
  function automatic logic lz_blank(input logic [31:0] digits, input logic [2:0] idx);
    return (idx != 3'd0) && ((digits >> (4 * idx)) == 32'd0);
  endfunction

endpackage

// File: rtl/decoder.sv
// BCD to active-low 7-segment decoder; codes 10..15 decode to all segments off.
module decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (code <= 4'd9) seg = SEG_DIGITS[code];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits, with a blanking
// gap between digits and a valid/ready value load that commits only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SHOW_CYC   = 50000,
  parameter int GAP_CYC    = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_tick
);

  localparam int MAX_CYC = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2((MAX_CYC < 2) ? 2 : MAX_CYC);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    advance;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] shadow_reg;
  logic [4*NUM_DIGITS-1:0] pend_buf_reg;
  logic                    pending_reg;

  logic [3:0]              code;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   one_hot;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_SHOW;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic; with no gap the show phase advances the digit itself.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    advance    = 1'b0;
    case (state_reg)
      S_SHOW: begin
        if (cnt_reg == SHOW_LAST) begin
          cnt_next = '0;
          if (GAP_CYC > 0) state_next = S_GAP;
          else             advance    = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = S_SHOW;
          advance    = 1'b1;
        end
      end
      default: begin
        state_next = S_SHOW;
        cnt_next   = '0;
      end
    endcase
    wrap = advance && (idx_reg == IDX_LAST);
    if (advance) idx_next = wrap ? '0 : idx_reg + 1'b1;
  end

  // Pending value is held until the next wrap so a frame never mixes values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg   <= '0;
      pend_buf_reg <= '0;
      pending_reg  <= 1'b0;
    end else if (wrap && pending_reg) begin
      shadow_reg  <= pend_buf_reg;
      pending_reg <= 1'b0;
    end else if (load_valid && load_ready) begin
      pend_buf_reg <= load_data;
      pending_reg  <= 1'b1;
    end
  end

  assign load_ready = ~pending_reg;

  always_comb begin
    code = shadow_reg[4*idx_reg +: 4];
    if (lz_en && lz_blank(32'(shadow_reg), 3'(idx_reg))) code = BLANK_CODE;
  end

  decoder u_decoder (
    .code (code),
    .seg  (dec_seg)
  );

  // Output logic
  always_comb begin
    one_hot  = NUM_DIGITS'(1) << idx_reg;
    an_next  = '1;
    seg_next = SEG_OFF;
    if (state_reg == S_SHOW) begin
      an_next  = ~one_hot;
      seg_next = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl: a gapped and a gapless build run side by side
// against a timeline-based reference model of the scan, handshake and blanking rules.
module tb_seg_scan_ctrl;

  localparam int N    = 4;
  localparam int SHOW = 4;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        lz_en;

  logic        ready_g, tick_g, ready_n, tick_n;
  logic [3:0]  an_g, an_n;
  logic [6:0]  seg_g, seg_n;

  int n_compared = 0;
  int n_mismatch = 0;

  int          k_m[2];
  logic [15:0] shadow_m[2];
  logic [15:0] pend_m[2];
  bit          pending_m[2];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(N), .SHOW_CYC(SHOW), .GAP_CYC(2)) dut_gap (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready_g),
    .lz_en      (lz_en),
    .an         (an_g),
    .seg        (seg_g),
    .frame_tick (tick_g)
  );

  seg_scan_ctrl #(.NUM_DIGITS(N), .SHOW_CYC(SHOW), .GAP_CYC(0)) dut_nogap (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (ready_n),
    .lz_en      (lz_en),
    .an         (an_n),
    .seg        (seg_n),
    .frame_tick (tick_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected outputs after the current edge, derived from elapsed cycles since release.
  task automatic model_and_check(input int m, input int gap,
                                 input logic [3:0] obs_an, input logic [6:0] obs_seg,
                                 input logic obs_tick, input logic obs_ready);
    logic [3:0] exp_an, one;
    logic [6:0] exp_seg;
    logic       exp_tick;
    int period, p, d, ph, code;
    string nm;
    nm = (m == 0) ? "gap" : "nogap";
    if (rst) begin
      exp_an       = 4'hF;
      exp_seg      = 7'h7F;
      exp_tick     = 1'b0;
      shadow_m[m]  = '0;
      pend_m[m]    = '0;
      pending_m[m] = 1'b0;
      k_m[m]       = 0;
    end else begin
      k_m[m]++;
      period = N * (SHOW + gap);
      p  = (k_m[m] - 1) % period;
      d  = p / (SHOW + gap);
      ph = p % (SHOW + gap);
      one = 4'b0001 << d;
      code = int'((shadow_m[m] >> (4 * d)) & 16'hF);
      if (lz_en && d > 0 && (shadow_m[m] >> (4 * d)) == 16'h0) code = 15;
      exp_an   = (ph < SHOW) ? ~one : 4'hF;
      exp_seg  = (ph < SHOW) ? ref_seg(code) : 7'h7F;
      exp_tick = (k_m[m] % period) == 0;
      if (exp_tick && pending_m[m]) begin
        shadow_m[m]  = pend_m[m];
        pending_m[m] = 1'b0;
      end else if (load_valid && !pending_m[m]) begin
        pend_m[m]    = load_data;
        pending_m[m] = 1'b1;
        if (m == 0) $display("load accepted: data=%h at cycle %0d", load_data, k_m[m]);
      end
    end
    check({nm, " an"},    32'(obs_an),    32'(exp_an));
    check({nm, " seg"},   32'(obs_seg),   32'(exp_seg));
    check({nm, " tick"},  32'(obs_tick),  32'(exp_tick));
    check({nm, " ready"}, 32'(obs_ready), 32'(!pending_m[m]));
  endtask

  initial begin
    logic [15:0] directed[5];
    directed[0] = 16'h1234;
    directed[1] = 16'h0007;
    directed[2] = 16'h00A5;
    directed[3] = 16'h0000;
    directed[4] = 16'h9999;
    for (int m = 0; m < 2; m++) begin
      k_m[m] = 0; shadow_m[m] = '0; pend_m[m] = '0; pending_m[m] = 1'b0;
    end
    rst = 1'b1; load_valid = 1'b0; load_data = '0; lz_en = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 15) == 0) load_valid = ~load_valid;
      if ($urandom_range(0, 3) == 0) load_data = directed[$urandom_range(0, 4)];
      else                           load_data = 16'($urandom);
      if (cyc == 5) begin
        load_valid = 1'b1;
        load_data  = 16'h1234;
      end
      @(posedge clk);
      #1;
      model_and_check(0, 2, an_g, seg_g, tick_g, ready_g);
      model_and_check(1, 0, an_n, seg_n, tick_n, ready_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one `decoder` instance.
- Holds a multi-digit BCD value and selects one digit at a time. It drives that digit's anode low and feeds its code through the shared decoder, with a blanking gap between digits to prevent ghosting.
- New values arrive through a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between the ALU result/BCD conversion logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- SHOW_CYC, 50000, clock cycles each digit is lit; must be ≥1.
- GAP_CYC, 500, clock cycles all anodes are off between digits; 0 means no gap.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- load_valid  input  1  a new display value is offered.
- load_data  input  4*NUM_DIGITS  BCD digits; nibble i drives anode i, and nibble 0 is the least significant digit.
- load_ready  output  1  the block can accept a value.
- lz_en  input  1  enables leading-zero blanking.
- an  output  NUM_DIGITS  anode enables, active-low.
- seg  output  7  segments, active-low, order {a,b,c,d,e,f,g}.
- frame_tick  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: one clock, synchronous and active-high; it takes effect at the rising edge of clk while rst=1.
  - Storage: shadow digits=0, pend_buf=0, pending=0.
  - FSM: S_SHOW, idx=0, cnt=0.
  - Outputs: an=all 1s, seg=7'b1111111, load_ready=1, frame_tick=0.
  - Reset asserted mid-scan or mid-handshake aborts immediately; the pending value is discarded.
- FSM states:
  - S_SHOW: lasts SHOW_CYC cycles. If GAP_CYC>0 the next state is S_GAP; otherwise the block advances the digit directly.
  - S_GAP: lasts GAP_CYC cycles, then advances the digit.
  - cnt runs 0..limit-1 and clears on each state change.
- Digit advance:
  - idx increments, and wraps from NUM_DIGITS-1 to 0.
  - On the wrap edge, frame_tick=1 for one cycle.
  - On the wrap edge, if pending=1, shadow<=pend_buf and pending<=0.
- Output registration:
  - an and seg are registered from FSM state, giving one cycle of latency.
  - In S_SHOW, an=~(1<<idx) and seg=decoder(code(idx)).
  - In S_GAP, an=all 1s and seg=7'b1111111.
- Timing: each digit is lit exactly SHOW_CYC cycles. The frame period is exactly NUM_DIGITS*(SHOW_CYC+GAP_CYC) cycles. The first lit cycle is the first edge after rst falls (an[0]=0).
- Handshake:
  - Transfer occurs when load_valid && load_ready; load_data is captured into pend_buf and pending<=1.
  - load_ready is registered and equals ~pending.
  - Because load_ready=0 whenever a value is pending, a second load cannot occur before the commit.
  - A transfer accepted on the same edge as a wrap is committed at the next wrap, not the current one.
  - load_data is ignored when load_valid=0.
- Digit code (code(idx)):
  - Normally shadow nibble idx.
  - If lz_en=1, idx>0, and shadow nibbles idx..NUM_DIGITS-1 are all 0, the code is BLANK_CODE (4'hF).
  - Digit 0 is never blanked.
  - lz_en is sampled live every cycle.
- Nibbles 10..15 pass through unchanged, and the decoder shows them blank (1111111).
- Counters use the minimum widths: $clog2(max(SHOW_CYC,GAP_CYC,2)) and $clog2(NUM_DIGITS).

Decomposition:
- Package seg_pkg holds:
  - BLANK_CODE = 4'hF.
  - SEG_OFF = 7'b1111111.
  - The state enum {S_SHOW, S_GAP}.
  - Segment patterns for digits 0..9, for benches.
- One sub-module instance: the existing `decoder`, fed with code(idx).
- The leading-zero mask is a small combinational function in the package.

Test Plan:
All scenarios use NUM_DIGITS=4, SHOW_CYC=4, GAP_CYC=2.
1. Reset release -> an=1110 with seg=0000001 for 4 cycles, then an=1111 for 2 cycles, then an=1101. The first frame_tick arrives 24 cycles after release.
2. Load 16'h1234 at cycle 3 -> load_ready goes low the next cycle. The displayed digits stay 0 until the wrap, then digit0 shows seg=1001100 (4) and digit3 shows seg=1001111 (1). load_ready returns high after the commit.
3. Hold load_valid across a frame -> exactly one transfer per frame. The second value appears only one full frame after the first.
4. Load 16'h0007 with lz_en=1 -> digits 3..1 show seg=1111111 and digit0 shows 0001111. With lz_en=0, digits 3..1 show 0000001.
5. Load 16'h00A5 -> digit1 shows seg=1111111 and digit0 shows 0100100. GAP_CYC=0 build -> no all-off cycles, and the frame period is 16.
6. Assert rst mid-S_SHOW while pending=1 -> the next cycle shows an=1111 and seg=1111111. After release, shadow=0 and the pending value never appears.
